// File: rtl/rv32i_types.sv
// Shared line and write-buffer entry types for the ewb_coalesce write buffer.
package rv32i_types;

    localparam int unsigned LINE_WIDTH = 256;
    localparam int unsigned ADDR_WIDTH = 32;

    typedef logic [LINE_WIDTH-1:0] line_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        line_t                 data;
    } ewb_entry_t;

endpackage

// File: rtl/ewb_match.sv
// Tag comparator across all entries, returning the youngest match counted from head.
module ewb_match #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 27
) (
    input  logic [DEPTH-1:0]            i_valid,
    input  logic [DEPTH-1:0][TAG_W-1:0] i_tag,
    input  logic [$clog2(DEPTH)-1:0]    i_head,
    input  logic [TAG_W-1:0]            i_key,
    input  logic                        i_skip_head,
    output logic                        o_hit,
    output logic [$clog2(DEPTH)-1:0]    o_idx
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_slot;

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        w_slot = i_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = i_head + PTR_W'(k);
            if (i_valid[w_slot] && (i_tag[w_slot] == i_key) && !(i_skip_head && (k == 0))) begin
                o_hit = 1'b1;
                o_idx = w_slot;
            end
        end
    end

endmodule

// File: rtl/ewb_coalesce.sv
// Coalescing eviction write buffer with forwarding probe.
// Define EWB_COALESCE_EN to merge writes to a line already queued behind the head.
module ewb_coalesce
    import rv32i_types::*;
#(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned OFFSET = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [31:0]              addr_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     lookup_i,
    input  logic [31:0]              lookup_addr_i,
    output logic                     hit_o,
    output logic [WIDTH-1:0]         read_o,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [31:0]              addr_o,
    input  logic                     yumi_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TAG_W = 32 - OFFSET;
`ifdef EWB_COALESCE_EN
    localparam bit COAL_EN = 1'b1;
`else
    localparam bit COAL_EN = 1'b0;
`endif

    ewb_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0][TAG_W-1:0] w_tag;
    logic                        w_c_hit;
    logic [PTR_W-1:0]            w_c_idx;
    logic                        w_p_hit;
    logic [PTR_W-1:0]            w_p_idx;
    logic                        w_coal;
    logic                        w_enq;
    logic                        w_deq;
    logic                        w_alloc;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = r_mem[i].valid;
            w_tag[i]   = r_mem[i].addr[31:OFFSET];
        end
    end

    // Head is excluded from coalescing since it may already be draining.
    ewb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_coal_match (
        .i_valid     (w_valid),
        .i_tag       (w_tag),
        .i_head      (r_head),
        .i_key       (addr_i[31:OFFSET]),
        .i_skip_head (1'b1),
        .o_hit       (w_c_hit),
        .o_idx       (w_c_idx)
    );

    ewb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_probe_match (
        .i_valid     (w_valid),
        .i_tag       (w_tag),
        .i_head      (r_head),
        .i_key       (lookup_addr_i[31:OFFSET]),
        .i_skip_head (1'b0),
        .o_hit       (w_p_hit),
        .o_idx       (w_p_idx)
    );

    assign w_coal  = COAL_EN & w_c_hit;
    assign ready_o = (r_count < CNT_W'(DEPTH)) | w_coal;
    assign valid_o = (r_count != '0);
    assign w_enq   = valid_i & ready_o;
    assign w_deq   = yumi_i & valid_o;
    assign w_alloc = w_enq & ~w_coal;

    assign data_o  = valid_o ? WIDTH'(r_mem[r_head].data) : '0;
    assign addr_o  = valid_o ? r_mem[r_head].addr : '0;
    assign hit_o   = lookup_i & w_p_hit;
    assign read_o  = hit_o ? WIDTH'(r_mem[w_p_idx].data) : '0;
    assign count_o = r_count;

    // Storage payload is never reset; only valid bits and pointers are.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else begin
            if (w_enq) begin
                if (w_coal) begin
                    r_mem[w_c_idx].data <= line_t'(data_i);
                end else begin
                    r_mem[r_tail].valid <= 1'b1;
                    r_mem[r_tail].addr  <= addr_i;
                    r_mem[r_tail].data  <= line_t'(data_i);
                    r_tail              <= r_tail + PTR_W'(1);
                end
            end
            if (w_deq) begin
                r_mem[r_head].valid <= 1'b0;
                r_head              <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_deq);
        end
    end

endmodule

// File: tb/tb_ewb_coalesce.sv
// Directed self-checking bench for ewb_coalesce (both EWB_COALESCE_EN builds).
module tb_ewb_coalesce;

    localparam int unsigned WIDTH = 256;
    localparam int unsigned DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_i;
    logic [31:0]      addr_i;
    logic             valid_i;
    logic             ready_o;
    logic             lookup_i;
    logic [31:0]      lookup_addr_i;
    logic             hit_o;
    logic [WIDTH-1:0] read_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic [31:0]      addr_o;
    logic             yumi_i;
    logic [3:0]       count_o;

    int checks  = 0;
    int errors  = 0;
    int n_alloc = 0;

    always #5 clk = ~clk;

    ewb_coalesce #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OFFSET(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .addr_i        (addr_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .lookup_i      (lookup_i),
        .lookup_addr_i (lookup_addr_i),
        .hit_o         (hit_o),
        .read_o        (read_o),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .addr_o        (addr_o),
        .yumi_i        (yumi_i),
        .count_o       (count_o)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [255:0] d, input bit alloc);
        addr_i  = a;
        data_i  = d;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        if (alloc) n_alloc++;
    endtask

    task automatic pop();
        yumi_i = 1'b1;
        @(posedge clk);
        #1;
        yumi_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; data_i = '0; addr_i = '0; valid_i = 1'b0;
        lookup_i = 1'b0; lookup_addr_i = '0; yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lookup_i = 1'b1;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_count", count_o, 0);
        check("rst_hit",   hit_o,   0);
        check("rst_data",  data_o,  0);
        check("rst_addr",  addr_o,  0);
        check("rst_read",  read_o,  0);
        lookup_i = 1'b0;
        rst      = 1'b1;

        // First enqueue into empty buffer: visible only after the edge
        addr_i = 32'h1000; data_i = 256'hA0; valid_i = 1'b1;
        #1;
        check("no_bypass", valid_o, 0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        n_alloc++;
        check("first_valid", valid_o, 1);
        check("first_data",  data_o,  256'hA0);
        check("first_addr",  addr_o,  32'h1000);
        for (int i = 1; i < 8; i++) push(32'h1000 + 32'(i) * 32'h20, 256'hA0 + 256'(i), 1'b1);
        check("full_count", count_o, 8);
        check("full_ready", ready_o, 0);

        addr_i = 32'h2000; data_i = 256'hFF; valid_i = 1'b1;
        #1;
        check("ninth_ready", ready_o, 0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("ninth_count", count_o, 8);
        check("ninth_head",  addr_o,  32'h1000);

        lookup_i = 1'b1; lookup_addr_i = 32'h1064;
        #1;
        check("full_probe_hit",  hit_o,  1);
        check("full_probe_read", read_o, 256'hA3);
        lookup_i = 1'b0;
        #1;
        check("probe_off_hit",  hit_o,  0);
        check("probe_off_read", read_o, 0);

        // Drain in enqueue order
        yumi_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_addr", addr_o, 32'h1000 + 32'(i) * 32'h20);
            @(posedge clk);
            #1;
        end
        yumi_i = 1'b0;
        check("drain_valid", valid_o, 0);
        check("drain_count", count_o, 0);
        pop();
        check("underflow_count", count_o, 0);

        push(32'h200, 256'hD0A, 1'b1);
        push(32'h240, 256'hB1,  1'b1);
`ifdef EWB_COALESCE_EN
        push(32'h244, 256'hB2, 1'b0);
        check("coal_count", count_o, 2);
        check("coal_a_addr", addr_o, 32'h200);
        check("coal_a_data", data_o, 256'hD0A);
        pop();
        check("coal_b_addr", addr_o, 32'h240);
        check("coal_b_data", data_o, 256'hB2);
        pop();
`else
        push(32'h244, 256'hB2, 1'b1);
        check("nocoal_count", count_o, 3);
        check("nocoal_a_data", data_o, 256'hD0A);
        pop();
        check("nocoal_b_data", data_o, 256'hB1);
        pop();
        check("nocoal_c_addr", addr_o, 32'h244);
        check("nocoal_c_data", data_o, 256'hB2);
        pop();
`endif
        check("coal_empty", valid_o, 0);

        // Same line twice: head never coalesced, probe returns youngest
        push(32'h100, 256'h11, 1'b1);
        push(32'h100, 256'h22, 1'b1);
        check("head_nocoal_count", count_o, 2);
        check("head_data", data_o, 256'h11);
        lookup_i = 1'b1; lookup_addr_i = 32'h104;
        #1;
        check("young_hit",  hit_o,  1);
        check("young_read", read_o, 256'h22);
        lookup_addr_i = 32'h300;
        #1;
        check("miss_hit",  hit_o,  0);
        check("miss_read", read_o, 0);
        lookup_i = 1'b0;
        pop();
        pop();

        // Align tail to slot 4, then fill three so the next alloc wraps 7 -> 0
        while ((n_alloc % 8) != 4) begin
            push(32'h5000 + 32'(n_alloc) * 32'h20, 256'h55, 1'b1);
            pop();
        end
        push(32'h3000, 256'h1, 1'b1);
        push(32'h3020, 256'h2, 1'b1);
        push(32'h3040, 256'h3, 1'b1);
        check("pre_wrap_count", count_o, 3);
        addr_i = 32'h3060; data_i = 256'h4; valid_i = 1'b1; yumi_i = 1'b1;
        @(posedge clk);
        #1;
        addr_i = 32'h3080; data_i = 256'h5;
        check("simul1_count", count_o, 3);
        check("simul1_head",  addr_o,  32'h3020);
        @(posedge clk);
        #1;
        valid_i = 1'b0; yumi_i = 1'b0;
        n_alloc += 2;
        check("simul2_count", count_o, 3);
        check("simul2_head",  addr_o,  32'h3040);
        check("wrap_d3", data_o, 256'h3);
        pop();
        check("wrap_d4", data_o, 256'h4);
        pop();
        check("wrap_addr5", addr_o, 32'h3080);
        check("wrap_d5",    data_o, 256'h5);
        pop();
        check("wrap_empty", valid_o, 0);

        // Reset collides with simultaneous enqueue and dequeue
        push(32'h600, 256'h66, 1'b1);
        push(32'h620, 256'h77, 1'b1);
        addr_i = 32'h640; data_i = 256'h88; valid_i = 1'b1; yumi_i = 1'b1; rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1; valid_i = 1'b0; yumi_i = 1'b0;
        lookup_i = 1'b1; lookup_addr_i = 32'h600;
        #1;
        check("rst2_count", count_o, 0);
        check("rst2_valid", valid_o, 0);
        check("rst2_hit",   hit_o,   0);
        check("rst2_read",  read_o,  0);
        check("rst2_ready", ready_o, 1);
        check("rst2_data",  data_o,  0);
        lookup_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ewb_coalesce.md
EWB_COALESCE -- requirements
Module: ewb_coalesce

Interface
REQ-001 Parameter WIDTH, default 256: line data width in bits.
REQ-002 Parameter DEPTH, default 8: entry count; power of two, at least 2.
REQ-003 Parameter OFFSET, default 5: line-offset bits; line tag = addr[31:OFFSET].
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-low.
REQ-006 data_i, addr_i, valid_i, ready_o  in/in/in/out  WIDTH/32/1/1  enqueue channel, valid-ready.
REQ-007 lookup_i, lookup_addr_i  input  1/32  forwarding probe.
REQ-008 hit_o, read_o  output  1/WIDTH  probe result.
REQ-009 valid_o, data_o, addr_o, yumi_i  out/out/out/in  1/WIDTH/32/1  drain channel, valid-yumi.
REQ-010 count_o  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-011 Circular buffer; head = oldest entry, tail = next free slot; pointers wrap DEPTH-1 -> 0.
REQ-012 Each entry holds a valid bit, data and address.
REQ-013 Enqueue fires when valid_i and ready_o are both high.
REQ-014 Dequeue fires when yumi_i and valid_o are both high; yumi_i with valid_o low is ignored.
REQ-015 valid_o = (count_o != 0); data_o/addr_o = head entry, combinational.
REQ-016 ready_o = (count_o < DEPTH) OR a coalesce match exists (REQ-019); ready_o does not depend on yumi_i.
REQ-017 Simultaneous enqueue (allocating) and dequeue: both pointers advance, count_o unchanged.
REQ-018 New entry appears on data_o one cycle after enqueue when buffer was empty; no bypass.
REQ-019 Coalesce match: a valid non-head entry whose tag equals addr_i[31:OFFSET] (head excluded because it may be in flight).
REQ-020 Enqueue with coalesce match overwrites that entry's data in place; no allocation, tail and count_o unchanged.
REQ-021 Enqueue with no match allocates at tail, even when the only matching entry is the head.
REQ-022 Probe: when lookup_i is high, hit_o is high if any valid entry's tag equals lookup_addr_i[31:OFFSET]; read_o carries the youngest matching entry's data.
REQ-023 When lookup_i is low or there is no match, hit_o = 0 and read_o = 0.
REQ-024 Probe sees state as of cycle start; same-cycle enqueue is invisible and same-cycle dequeued head is still visible.
REQ-025 No overflow or underflow; count_o stays within 0..DEPTH.

Reset
REQ-026 rst low at a clock edge: head, tail and count cleared; all valid bits cleared; any in-progress enqueue or dequeue is discarded.
REQ-027 Outputs after reset: valid_o = 0, ready_o = 1, hit_o = 0, count_o = 0, data_o = 0, addr_o = 0, read_o = 0.
REQ-028 Entry data and address storage is not cleared by reset; outputs are gated by the valid bits.

Configuration
REQ-029 Macro EWB_COALESCE_EN: when defined, REQ-019 and REQ-020 apply.
REQ-030 Without EWB_COALESCE_EN, every enqueue allocates and ready_o = (count_o < DEPTH); the probe still returns the youngest match.

Structure
REQ-031 Shared line typedef (WIDTH-bit data) and entry struct (valid, addr, data) live in rv32i_types.
REQ-032 One sub-module, ewb_match: a DEPTH-wide tag comparator plus youngest-match priority encoder, relative to head.
REQ-033 ewb_match is instantiated twice, once for the coalesce match and once for the probe.

Verification
REQ-034 Reset, then fill with 8 distinct lines, no yumi -> ready_o = 0 and count_o = 8 after the 8th enqueue; a 9th enqueue is refused.
REQ-035 Full buffer, yumi_i held for 8 cycles -> addresses drain in enqueue order, then valid_o = 0.
REQ-036 EWB_COALESCE_EN defined: enqueue A, then B, then B again with new data -> count_o = 2, drained B carries the new data.
REQ-037 Enqueue 0x100 (becomes head), then 0x100 again -> count_o = 2 (head not coalesced); probe 0x104 -> hit_o = 1, read_o = second data.
REQ-038 Enqueue and yumi asserted in the same cycle at count_o = 3 -> count_o stays 3; tail wraps 7 -> 0 correctly.
REQ-039 rst low during a simultaneous enqueue and yumi -> next cycle count_o = 0, valid_o = 0, hit_o = 0.
